snake_pixel_renderer: RTL and testbench
=======================================

// Module: snake_pixel_renderer
// PURPOSE
//  Pixel stage directly downstream of the VGA timing generator. Consumes x_pos/y_pos/display_enable/hsync/vsync.
//  Maps each pixel to a 16x16 grid cell (40x30 grid) and colours it from the snake state: border, head, body, food.
//  Game logic writes the snake state into a shadow buffer. The buffer is committed to the active copy only at vblank start.
//  This prevents tearing. Outputs RGB plus hsync/vsync delayed to stay aligned with the colour data.
// PARAMETERS
//  MAX_LEN     32   max snake segments held (segment 0 = head)
//  CELL_SHIFT  4    log2 of cell size in pixels
//  COLOR_W     4    bits per colour channel
//  H_ACTIVE    640  visible pixels per line
//  V_ACTIVE    480  visible lines per frame
// PORTS
//  VGA_clk        in   1     pixel clock
//  reset          in   1     synchronous, active-high
//  x_pos          in   10    current column from sync stage
//  y_pos          in   10    current line from sync stage
//  display_enable in   1     visible-area flag from sync stage
//  hsync_in       in   1     hsync from sync stage (active-low)
//  vsync_in       in   1     vsync from sync stage (active-low)
//  seg_we         in   1     write one segment into shadow
//  seg_idx        in   5     segment index (log2 MAX_LEN)
//  seg_cx         in   6     segment cell column 0..39
//  seg_cy         in   5     segment cell row 0..29
//  len_we         in   1     write snake length into shadow
//  len_in         in   6     snake length 0..MAX_LEN
//  food_we        in   1     write food cell into shadow
//  food_cx        in   6     food cell column
//  food_cy        in   5     food cell row
//  commit_req     in   1     request shadow->active copy at next vblank
//  commit_done    out  1     1-cycle pulse on the cycle the copy happens
//  frame_tick     out  1     1-cycle pulse at vblank start (every frame)
//  red/green/blue out  COLOR_W each  pixel colour
//  hsync/vsync    out  1     sync delayed to match colour latency
// BEHAVIOUR
//  Reset: all outputs 0 except hsync/vsync = 1. Shadow and active state clear: len 0, food (0,0), segments (0,0).
//   commit_pending = 0.
//  Latency: 3 cycles from x_pos/y_pos/display_enable/hsync_in/vsync_in to RGB/hsync/vsync, for every pixel.
//   S1 registers cell_x = x_pos>>CELL_SHIFT, cell_y = y_pos>>CELL_SHIFT, de, syncs.
//   S2 registers the hit flags: head_hit, body_hit (OR over idx 1..len-1), food_hit, border_hit.
//   S3 registers the priority-muxed colour.
//  Priority: de=0 -> black; border (cell_x 0 or 39, cell_y 0 or 29) -> white; head -> yellow; body -> green;
//   food -> red; otherwise dark blue. Colour constants come from the shared header.
//  Segments with idx >= len never hit. len 0 -> no head, no body. len_in > MAX_LEN clamps to MAX_LEN.
//  Shadow writes apply on the cycle after the *_we pulse. Several *_we may assert in the same cycle; all apply.
//   seg_idx >= MAX_LEN is ignored.
//  commit_req sets commit_pending; extra requests before the commit merge into one.
//  Vblank start is the cycle with x_pos==0 && y_pos==V_ACTIVE; frame_tick is registered from it (pulses next cycle).
//   If commit_pending is set at vblank start, active <= shadow, commit_done pulses (same cycle as frame_tick),
//   and commit_pending clears.
//  Shadow writes on the vblank-start cycle do not reach active; they wait for the next commit.
//  commit_req on the vblank-start cycle is taken for the next frame.
//  Active state never changes during the visible area, so a frame is always rendered from one consistent snapshot.
//  Reset mid-frame: state clears; the pipeline outputs black/inactive syncs until reset drops, then resumes
//   tracking the inputs after 3 cycles.
// STRUCTURE
//  Shared header snake_defs.vh: GRID_W=40, GRID_H=30, colour localparams (WHITE, YELLOW, GREEN, RED, BG, BLACK),
//   MAX_LEN default.
//  Sub-module snake_segment_store: shadow and active register files, length and food registers, commit_pending,
//   commit logic. Exposes the active arrays to the renderer. The top holds the 3-stage pipeline and comparators.
// TESTING
//  Reset held 5 cycles -> RGB=0, hsync=vsync=1, commit_done=0; len=0 commit -> only border and background drawn.
//  Write len=3, segs (10,10),(9,10),(8,10), food (20,15), commit, run frame ->
//   pixel (160,160) yellow, (144,160) green, (320,240) red, (0,0) white.
//  Latency: step x_pos across a cell edge, toggle hsync_in -> colour and hsync change exactly 3 cycles later.
//  Write new head (11,10) mid-visible-area with commit_req -> current frame unchanged;
//   next frame shows the new head; commit_done pulses once.
//  len_in=40 -> clamps to 32; seg_idx writes beyond 31 are ignored.
//   seg_we and food_we fire on the vblank-start cycle -> deferred to the next commit.
//  Assert reset mid-line -> outputs go to reset values next cycle; after release the pixels at 3-cycle latency match
//   the golden model.

Source files
------------

// File: rtl/snake_pixel_renderer_pkg.sv
// Shared definitions for the snake pixel renderer: grid geometry, field
// widths, colour constants and the length clamp helper.
// No ports; imported by the interface, the segment store and the top.
package snake_pixel_renderer_pkg;

    localparam int MAX_LEN    = 32;
    localparam int IDX_W      = $clog2(MAX_LEN);
    localparam int LEN_W      = $clog2(MAX_LEN) + 1;
    localparam int CELL_SHIFT = 4;
    localparam int COLOR_W    = 4;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int POS_W      = 10;
    localparam int CELL_W     = POS_W - CELL_SHIFT;
    localparam int CX_W       = 6;
    localparam int CY_W       = 5;
    localparam int GRID_W     = H_ACTIVE >> CELL_SHIFT;
    localparam int GRID_H     = V_ACTIVE >> CELL_SHIFT;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t WHITE  = 12'hFFF;
    localparam rgb_t YELLOW = 12'hFF0;
    localparam rgb_t GREEN  = 12'h0F0;
    localparam rgb_t RED    = 12'hF00;
    localparam rgb_t BG     = 12'h006;
    localparam rgb_t BLACK  = 12'h000;

    // Lengths beyond the register file saturate rather than wrap.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/snake_pixel_renderer_if.sv
// Game-logic write bus into the renderer's shadow snake state.
// master: game logic (drives writes and commit_req, sees commit_done).
// slave : renderer (receives writes, returns the commit_done pulse).
interface snake_pixel_renderer_if;
    import snake_pixel_renderer_pkg::*;

    logic             seg_we;
    logic [IDX_W-1:0] seg_idx;
    logic [CX_W-1:0]  seg_cx;
    logic [CY_W-1:0]  seg_cy;
    logic             len_we;
    logic [LEN_W-1:0] len_in;
    logic             food_we;
    logic [CX_W-1:0]  food_cx;
    logic [CY_W-1:0]  food_cy;
    logic             commit_req;
    logic             commit_done;

    modport master (
        output seg_we, seg_idx, seg_cx, seg_cy,
        output len_we, len_in, food_we, food_cx, food_cy,
        output commit_req,
        input  commit_done
    );

    modport slave (
        input  seg_we, seg_idx, seg_cx, seg_cy,
        input  len_we, len_in, food_we, food_cx, food_cy,
        input  commit_req,
        output commit_done
    );
endinterface

// File: rtl/snake_pixel_renderer_segment_store.sv
// snake_segment_store: shadow and active copies of the snake state.
// Ports: clk/reset; bus (slave write port, drives commit_done);
// vblank_start (copy trigger); act_* (active snapshot for the renderer).
module snake_segment_store
    import snake_pixel_renderer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    snake_pixel_renderer_if.slave bus,
    input  logic                  vblank_start,
    output logic [CX_W-1:0]       act_cx [MAX_LEN],
    output logic [CY_W-1:0]       act_cy [MAX_LEN],
    output logic [LEN_W-1:0]      act_len,
    output logic [CX_W-1:0]       act_food_cx,
    output logic [CY_W-1:0]       act_food_cy
);

    logic [CX_W-1:0]  sh_cx [MAX_LEN];
    logic [CY_W-1:0]  sh_cy [MAX_LEN];
    logic [LEN_W-1:0] sh_len;
    logic [CX_W-1:0]  sh_food_cx;
    logic [CY_W-1:0]  sh_food_cy;
    logic             commit_pending;

    // seg_idx is exactly log2(MAX_LEN) wide, so every encodable index is a
    // valid slot and no out-of-range filtering is needed.
    // The active copy samples the shadow's pre-edge contents, so shadow writes
    // landing on the vblank-start cycle wait for the next commit. A commit_req
    // arriving on that same cycle re-arms the pending flag for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                sh_cx[i]  <= '0;
                sh_cy[i]  <= '0;
                act_cx[i] <= '0;
                act_cy[i] <= '0;
            end
            sh_len          <= '0;
            sh_food_cx      <= '0;
            sh_food_cy      <= '0;
            act_len         <= '0;
            act_food_cx     <= '0;
            act_food_cy     <= '0;
            commit_pending  <= 1'b0;
            bus.commit_done <= 1'b0;
        end else begin
            if (bus.seg_we) begin
                sh_cx[bus.seg_idx] <= bus.seg_cx;
                sh_cy[bus.seg_idx] <= bus.seg_cy;
            end
            if (bus.len_we) begin
                sh_len <= clamp_len(bus.len_in);
            end
            if (bus.food_we) begin
                sh_food_cx <= bus.food_cx;
                sh_food_cy <= bus.food_cy;
            end
            bus.commit_done <= 1'b0;
            if (vblank_start && commit_pending) begin
                act_cx          <= sh_cx;
                act_cy          <= sh_cy;
                act_len         <= sh_len;
                act_food_cx     <= sh_food_cx;
                act_food_cy     <= sh_food_cy;
                bus.commit_done <= 1'b1;
                commit_pending  <= bus.commit_req;
            end else if (bus.commit_req) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_pixel_renderer.sv
// snake_pixel_renderer: colours each VGA pixel from the snake state with a
// fixed 3-cycle latency (cell lookup, hit detection, colour select).
// Ports: VGA_clk/reset; x_pos/y_pos/display_enable/hsync_in/vsync_in from the
// sync stage; bus (game write port); frame_tick; red/green/blue; hsync/vsync.
module snake_pixel_renderer
    import snake_pixel_renderer_pkg::*;
(
    input  logic                  VGA_clk,
    input  logic                  reset,
    input  logic [POS_W-1:0]      x_pos,
    input  logic [POS_W-1:0]      y_pos,
    input  logic                  display_enable,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    snake_pixel_renderer_if.slave bus,
    output logic                  frame_tick,
    output logic [COLOR_W-1:0]    red,
    output logic [COLOR_W-1:0]    green,
    output logic [COLOR_W-1:0]    blue,
    output logic                  hsync,
    output logic                  vsync
);

    logic [CX_W-1:0]  act_cx [MAX_LEN];
    logic [CY_W-1:0]  act_cy [MAX_LEN];
    logic [LEN_W-1:0] act_len;
    logic [CX_W-1:0]  act_food_cx;
    logic [CY_W-1:0]  act_food_cy;
    logic             vblank_start;

    logic [CELL_W-1:0] s1_cx, s1_cy;
    logic              s1_de, s1_hs, s1_vs;
    logic              head_c, body_c, food_c, border_c;
    logic              s2_head, s2_body, s2_food, s2_border;
    logic              s2_de, s2_hs, s2_vs;
    rgb_t              colour;

    assign vblank_start = (x_pos == '0) && (y_pos == POS_W'(V_ACTIVE));

    snake_segment_store u_store (
        .clk          (VGA_clk),
        .reset        (reset),
        .bus          (bus),
        .vblank_start (vblank_start),
        .act_cx       (act_cx),
        .act_cy       (act_cy),
        .act_len      (act_len),
        .act_food_cx  (act_food_cx),
        .act_food_cy  (act_food_cy)
    );

    // Hit detection against the active snapshot; segments at or beyond the
    // current length are masked so stale entries never draw.
    always_comb begin
        head_c   = 1'b0;
        body_c   = 1'b0;
        food_c   = (s1_cx == act_food_cx) && (s1_cy == CELL_W'(act_food_cy));
        border_c = (s1_cx == '0) || (s1_cx == CELL_W'(GRID_W - 1)) ||
                   (s1_cy == '0) || (s1_cy == CELL_W'(GRID_H - 1));
        if (act_len != '0) begin
            head_c = (s1_cx == act_cx[0]) && (s1_cy == CELL_W'(act_cy[0]));
        end
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < act_len) && (s1_cx == act_cx[i]) &&
                (s1_cy == CELL_W'(act_cy[i]))) begin
                body_c = 1'b1;
            end
        end
    end

    // Priority colour select: blanking, border, head, body, food, background.
    always_comb begin
        colour = BLACK;
        if (!s2_de)         colour = BLACK;
        else if (s2_border) colour = WHITE;
        else if (s2_head)   colour = YELLOW;
        else if (s2_body)   colour = GREEN;
        else if (s2_food)   colour = RED;
        else                colour = BG;
    end

    // Three register stages; syncs travel alongside so they stay aligned with
    // colour, and reset parks every stage at blank with inactive syncs.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            s1_cx      <= '0;
            s1_cy      <= '0;
            s1_de      <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s2_head    <= 1'b0;
            s2_body    <= 1'b0;
            s2_food    <= 1'b0;
            s2_border  <= 1'b0;
            s2_de      <= 1'b0;
            s2_hs      <= 1'b1;
            s2_vs      <= 1'b1;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            s1_cx      <= x_pos[POS_W-1:CELL_SHIFT];
            s1_cy      <= y_pos[POS_W-1:CELL_SHIFT];
            s1_de      <= display_enable;
            s1_hs      <= hsync_in;
            s1_vs      <= vsync_in;
            s2_head    <= head_c;
            s2_body    <= body_c;
            s2_food    <= food_c;
            s2_border  <= border_c;
            s2_de      <= s1_de;
            s2_hs      <= s1_hs;
            s2_vs      <= s1_vs;
            red        <= colour.r;
            green      <= colour.g;
            blue       <= colour.b;
            hsync      <= s2_hs;
            vsync      <= s2_vs;
            frame_tick <= vblank_start;
        end
    end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer: drives pixel positions and the
// game write bus, compares colour/sync/pulse outputs to hand-derived values.
module tb_snake_pixel_renderer;

    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_GREEN  = 12'h0F0;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_BG     = 12'h006;
    localparam logic [11:0] C_BLACK  = 12'h000;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic [9:0] x_pos, y_pos;
    logic       de, hsync_in, vsync_in;
    logic       frame_tick;
    logic [3:0] red, green, blue;
    logic       hsync, vsync;

    int vectors     = 0;
    int miscompares = 0;

    snake_pixel_renderer_if bus();

    snake_pixel_renderer dut (
        .VGA_clk        (VGA_clk),
        .reset          (reset),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .display_enable (de),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .bus            (bus),
        .frame_tick     (frame_tick),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync)
    );

    initial forever #5 VGA_clk = ~VGA_clk;

    task automatic park();
        x_pos = 10'd700; y_pos = 10'd500; de = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic drive_pixel(input int x, input int y, input bit en);
        x_pos = 10'(x); y_pos = 10'(y); de = en; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(negedge VGA_clk);
    endtask

    task automatic write_seg(input int idx, input int cx, input int cy);
        bus.seg_we = 1'b1; bus.seg_idx = 5'(idx); bus.seg_cx = 6'(cx); bus.seg_cy = 5'(cy);
        @(negedge VGA_clk);
        bus.seg_we = 1'b0;
    endtask

    task automatic write_len(input int len);
        bus.len_we = 1'b1; bus.len_in = 6'(len);
        @(negedge VGA_clk);
        bus.len_we = 1'b0;
    endtask

    task automatic write_food(input int cx, input int cy);
        bus.food_we = 1'b1; bus.food_cx = 6'(cx); bus.food_cy = 5'(cy);
        @(negedge VGA_clk);
        bus.food_we = 1'b0;
    endtask

    task automatic request_commit();
        bus.commit_req = 1'b1;
        @(negedge VGA_clk);
        bus.commit_req = 1'b0;
    endtask

    task automatic do_vblank(input string tag, input bit exp_done);
        x_pos = 10'd0; y_pos = 10'd480; de = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
        @(negedge VGA_clk);
        vectors++;
        if (frame_tick !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s frame_tick: got %b expected 1", tag, frame_tick);
        end
        vectors++;
        if (bus.commit_done !== exp_done) begin
            miscompares++;
            $display("[TB] FAIL %s commit_done: got %b expected %b", tag, bus.commit_done, exp_done);
        end
        park();
        @(negedge VGA_clk);
        vectors++;
        if (frame_tick !== 1'b0 || bus.commit_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s pulse width: got tick=%b done=%b expected 0/0", tag, frame_tick, bus.commit_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x_pos = 10'd100; y_pos = 10'd100; de = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (5) @(negedge VGA_clk);
        vectors++;
        if ({red, green, blue} !== C_BLACK || hsync !== 1'b1 || vsync !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got rgb=%h hs=%b vs=%b expected 000/1/1", {red, green, blue}, hsync, vsync);
        end
        vectors++;
        if (bus.commit_done !== 1'b0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset pulses: got done=%b tick=%b expected 0/0", bus.commit_done, frame_tick);
        end
        park();
        reset = 1'b0;
        @(negedge VGA_clk);
    endtask

    task automatic test_empty_frame();
        int          px [5] = '{0, 639, 160, 320, 160};
        int          py [5] = '{0, 479, 160, 240, 160};
        bit          pe [5] = '{1, 1, 1, 1, 0};
        logic [11:0] ex [5] = '{C_WHITE, C_WHITE, C_BG, C_BG, C_BLACK};
        request_commit();
        do_vblank("empty_vblank", 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_pixel(px[i], py[i], pe[i]);
            vectors++;
            if ({red, green, blue} !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL empty pixel(%0d,%0d): got %h expected %h", px[i], py[i], {red, green, blue}, ex[i]);
            end
        end
        park();
    endtask

    task automatic test_render();
        int          px [7] = '{160, 144, 128, 320, 0, 400, 176};
        int          py [7] = '{160, 160, 160, 240, 0, 320, 160};
        logic [11:0] ex [7] = '{C_YELLOW, C_GREEN, C_GREEN, C_RED, C_WHITE, C_BG, C_BG};
        write_len(3);
        write_seg(0, 10, 10);
        write_seg(1, 9, 10);
        write_seg(2, 8, 10);
        write_seg(5, 25, 20);
        write_food(20, 15);
        drive_pixel(160, 160, 1'b1);
        vectors++;
        if ({red, green, blue} !== C_BG) begin
            miscompares++;
            $display("[TB] FAIL render precommit: got %h expected %h", {red, green, blue}, C_BG);
        end
        park();
        request_commit();
        do_vblank("render_vblank", 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive_pixel(px[i], py[i], 1'b1);
            vectors++;
            if ({red, green, blue} !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL render pixel(%0d,%0d): got %h expected %h", px[i], py[i], {red, green, blue}, ex[i]);
            end
        end
        park();
    endtask

    task automatic test_latency();
        int          xs [10] = '{150, 152, 154, 156, 158, 160, 162, 175, 176, 178};
        bit          hs [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};
        logic [11:0] ex [10] = '{C_GREEN, C_GREEN, C_GREEN, C_GREEN, C_GREEN,
                                 C_YELLOW, C_YELLOW, C_YELLOW, C_BG, C_BG};
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                x_pos = 10'(xs[k]); y_pos = 10'd160; de = 1'b1; hsync_in = hs[k]; vsync_in = 1'b1;
            end
            @(negedge VGA_clk);
            if (k >= 2) begin
                vectors++;
                if ({red, green, blue} !== ex[k-2] || hsync !== hs[k-2] || vsync !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL latency step %0d: got rgb=%h hs=%b vs=%b expected %h/%b/1",
                             k - 2, {red, green, blue}, hsync, vsync, ex[k-2], hs[k-2]);
                end
            end
        end
        park();
    endtask

    task automatic test_midframe_commit();
        drive_pixel(160, 160, 1'b1);
        write_seg(0, 11, 10);
        request_commit();
        drive_pixel(160, 160, 1'b1);
        vectors++;
        if ({red, green, blue} !== C_YELLOW) begin
            miscompares++;
            $display("[TB] FAIL midframe old head: got %h expected %h", {red, green, blue}, C_YELLOW);
        end
        drive_pixel(176, 160, 1'b1);
        vectors++;
        if ({red, green, blue} !== C_BG || bus.commit_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe new cell early: got rgb=%h done=%b expected %h/0", {red, green, blue}, bus.commit_done, C_BG);
        end
        park();
        do_vblank("midframe_vblank", 1'b1);
        drive_pixel(176, 160, 1'b1);
        vectors++;
        if ({red, green, blue} !== C_YELLOW) begin
            miscompares++;
            $display("[TB] FAIL midframe new head: got %h expected %h", {red, green, blue}, C_YELLOW);
        end
        drive_pixel(160, 160, 1'b1);
        vectors++;
        if ({red, green, blue} !== C_BG) begin
            miscompares++;
            $display("[TB] FAIL midframe vacated cell: got %h expected %h", {red, green, blue}, C_BG);
        end
        park();
        do_vblank("midframe_idle_vblank", 1'b0);
    endtask

    task automatic test_clamp();
        int          px [6] = '{480, 480, 400, 176, 160, 320};
        int          py [6] = '{80, 96, 320, 160, 160, 240};
        logic [11:0] ex [6] = '{C_GREEN, C_GREEN, C_GREEN, C_YELLOW, C_BG, C_RED};
        write_seg(31, 30, 5);
        write_seg(20, 30, 6);
        write_len(40);
        request_commit();
        do_vblank("clamp_vblank", 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_pixel(px[i], py[i], 1'b1);
            vectors++;
            if ({red, green, blue} !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL clamp pixel(%0d,%0d): got %h expected %h", px[i], py[i], {red, green, blue}, ex[i]);
            end
        end
        park();
    endtask

    task automatic test_vblank_writes();
        int          px [5] = '{80, 80, 320, 176, 144};
        int          py [5] = '{80, 96, 240, 160, 160};
        logic [11:0] e1 [5] = '{C_BG, C_BG, C_RED, C_YELLOW, C_GREEN};
        logic [11:0] e2 [5] = '{C_YELLOW, C_RED, C_BG, C_BG, C_GREEN};
        request_commit();
        x_pos = 10'd0; y_pos = 10'd480; de = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
        bus.seg_we = 1'b1; bus.seg_idx = 5'd0; bus.seg_cx = 6'd5; bus.seg_cy = 5'd5;
        bus.food_we = 1'b1; bus.food_cx = 6'd5; bus.food_cy = 5'd6;
        bus.commit_req = 1'b1;
        @(negedge VGA_clk);
        bus.seg_we = 1'b0; bus.food_we = 1'b0; bus.commit_req = 1'b0;
        vectors++;
        if (frame_tick !== 1'b1 || bus.commit_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL vbw commit pulses: got tick=%b done=%b expected 1/1", frame_tick, bus.commit_done);
        end
        park();
        for (int i = 0; i < 5; i++) begin
            drive_pixel(px[i], py[i], 1'b1);
            vectors++;
            if ({red, green, blue} !== e1[i]) begin
                miscompares++;
                $display("[TB] FAIL vbw deferred pixel(%0d,%0d): got %h expected %h", px[i], py[i], {red, green, blue}, e1[i]);
            end
        end
        park();
        do_vblank("vbw_next_vblank", 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_pixel(px[i], py[i], 1'b1);
            vectors++;
            if ({red, green, blue} !== e2[i]) begin
                miscompares++;
                $display("[TB] FAIL vbw applied pixel(%0d,%0d): got %h expected %h", px[i], py[i], {red, green, blue}, e2[i]);
            end
        end
        park();
    endtask

    task automatic test_reset_midline();
        logic [11:0] ex [3] = '{C_BLACK, C_BLACK, C_BG};
        bit          eh [3] = '{1, 1, 0};
        x_pos = 10'd80; y_pos = 10'd80; de = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
        repeat (3) @(negedge VGA_clk);
        vectors++;
        if ({red, green, blue} !== C_YELLOW || hsync !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid before: got rgb=%h hs=%b expected %h/0", {red, green, blue}, hsync, C_YELLOW);
        end
        reset = 1'b1;
        @(negedge VGA_clk);
        vectors++;
        if ({red, green, blue} !== C_BLACK || hsync !== 1'b1 || vsync !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstmid during: got rgb=%h hs=%b vs=%b expected 000/1/1", {red, green, blue}, hsync, vsync);
        end
        @(negedge VGA_clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge VGA_clk);
            vectors++;
            if ({red, green, blue} !== ex[k] || hsync !== eh[k]) begin
                miscompares++;
                $display("[TB] FAIL rstmid after step %0d: got rgb=%h hs=%b expected %h/%b",
                         k, {red, green, blue}, hsync, ex[k], eh[k]);
            end
        end
        park();
    endtask

    initial begin
        bus.seg_we = 1'b0; bus.seg_idx = '0; bus.seg_cx = '0; bus.seg_cy = '0;
        bus.len_we = 1'b0; bus.len_in = '0;
        bus.food_we = 1'b0; bus.food_cx = '0; bus.food_cy = '0;
        bus.commit_req = 1'b0;
        park();
        test_reset();
        test_empty_frame();
        test_render();
        test_latency();
        test_midframe_commit();
        test_clamp();
        test_vblank_writes();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
